// File: rtl/mp3_sine_gen.sv
// Free-running 512-sample sine generator for a 10-bit parallel R-2R DAC.
// A quarter-wave ROM is mirrored and inverted by quadrant. The sample is registered before it reaches the pins.
module mp3_sine_gen (
  input  logic clk,
  input  logic rst_n,
  output logic dac_bit9,
  output logic dac_bit8,
  output logic dac_bit7,
  output logic dac_bit6,
  output logic dac_bit5,
  output logic dac_bit4,
  output logic dac_bit3,
  output logic dac_bit2,
  output logic dac_bit1,
  output logic dac_bit0
);

  logic [8:0] phase;
  logic [9:0] sample;
  logic [1:0] quad;
  logic [6:0] idx;
  logic [6:0] addr;
  logic [8:0] qval;
  logic [9:0] next_sample;

  assign quad = phase[8:7];
  assign idx  = phase[6:0];
  // Odd quadrants read the quarter table backwards.
  assign addr = quad[0] ? (7'd127 - idx) : idx;

  // round(511*sin(2*pi*(k+0.5)/512)). The half-sample offset keeps midscale out of the run-time output.
  always_comb begin
    qval = '0;
    case (addr)
      7'd0:   qval = 9'd3;
      7'd1:   qval = 9'd9;
      7'd2:   qval = 9'd16;
      7'd3:   qval = 9'd22;
      7'd4:   qval = 9'd28;
      7'd5:   qval = 9'd34;
      7'd6:   qval = 9'd41;
      7'd7:   qval = 9'd47;
      7'd8:   qval = 9'd53;
      7'd9:   qval = 9'd59;
      7'd10:  qval = 9'd66;
      7'd11:  qval = 9'd72;
      7'd12:  qval = 9'd78;
      7'd13:  qval = 9'd84;
      7'd14:  qval = 9'd90;
      7'd15:  qval = 9'd97;
      7'd16:  qval = 9'd103;
      7'd17:  qval = 9'd109;
      7'd18:  qval = 9'd115;
      7'd19:  qval = 9'd121;
      7'd20:  qval = 9'd127;
      7'd21:  qval = 9'd133;
      7'd22:  qval = 9'd139;
      7'd23:  qval = 9'd145;
      7'd24:  qval = 9'd151;
      7'd25:  qval = 9'd157;
      7'd26:  qval = 9'd163;
      7'd27:  qval = 9'd169;
      7'd28:  qval = 9'd175;
      7'd29:  qval = 9'd181;
      7'd30:  qval = 9'd187;
      7'd31:  qval = 9'd193;
      7'd32:  qval = 9'd198;
      7'd33:  qval = 9'd204;
      7'd34:  qval = 9'd210;
      7'd35:  qval = 9'd216;
      7'd36:  qval = 9'd221;
      7'd37:  qval = 9'd227;
      7'd38:  qval = 9'd233;
      7'd39:  qval = 9'd238;
      7'd40:  qval = 9'd244;
      7'd41:  qval = 9'd249;
      7'd42:  qval = 9'd255;
      7'd43:  qval = 9'd260;
      7'd44:  qval = 9'd265;
      7'd45:  qval = 9'd271;
      7'd46:  qval = 9'd276;
      7'd47:  qval = 9'd281;
      7'd48:  qval = 9'd286;
      7'd49:  qval = 9'd292;
      7'd50:  qval = 9'd297;
      7'd51:  qval = 9'd302;
      7'd52:  qval = 9'd307;
      7'd53:  qval = 9'd312;
      7'd54:  qval = 9'd317;
      7'd55:  qval = 9'd322;
      7'd56:  qval = 9'd327;
      7'd57:  qval = 9'd331;
      7'd58:  qval = 9'd336;
      7'd59:  qval = 9'd341;
      7'd60:  qval = 9'd345;
      7'd61:  qval = 9'd350;
      7'd62:  qval = 9'd355;
      7'd63:  qval = 9'd359;
      7'd64:  qval = 9'd364;
      7'd65:  qval = 9'd368;
      7'd66:  qval = 9'd372;
      7'd67:  qval = 9'd377;
      7'd68:  qval = 9'd381;
      7'd69:  qval = 9'd385;
      7'd70:  qval = 9'd389;
      7'd71:  qval = 9'd393;
      7'd72:  qval = 9'd397;
      7'd73:  qval = 9'd401;
      7'd74:  qval = 9'd405;
      7'd75:  qval = 9'd409;
      7'd76:  qval = 9'd412;
      7'd77:  qval = 9'd416;
      7'd78:  qval = 9'd420;
      7'd79:  qval = 9'd423;
      7'd80:  qval = 9'd427;
      7'd81:  qval = 9'd430;
      7'd82:  qval = 9'd433;
      7'd83:  qval = 9'd437;
      7'd84:  qval = 9'd440;
      7'd85:  qval = 9'd443;
      7'd86:  qval = 9'd446;
      7'd87:  qval = 9'd449;
      7'd88:  qval = 9'd452;
      7'd89:  qval = 9'd455;
      7'd90:  qval = 9'd458;
      7'd91:  qval = 9'd461;
      7'd92:  qval = 9'd463;
      7'd93:  qval = 9'd466;
      7'd94:  qval = 9'd468;
      7'd95:  qval = 9'd471;
      7'd96:  qval = 9'd473;
      7'd97:  qval = 9'd476;
      7'd98:  qval = 9'd478;
      7'd99:  qval = 9'd480;
      7'd100: qval = 9'd482;
      7'd101: qval = 9'd484;
      7'd102: qval = 9'd486;
      7'd103: qval = 9'd488;
      7'd104: qval = 9'd490;
      7'd105: qval = 9'd492;
      7'd106: qval = 9'd493;
      7'd107: qval = 9'd495;
      7'd108: qval = 9'd496;
      7'd109: qval = 9'd498;
      7'd110: qval = 9'd499;
      7'd111: qval = 9'd501;
      7'd112: qval = 9'd502;
      7'd113: qval = 9'd503;
      7'd114: qval = 9'd504;
      7'd115: qval = 9'd505;
      7'd116: qval = 9'd506;
      7'd117: qval = 9'd507;
      7'd118: qval = 9'd508;
      7'd119: qval = 9'd508;
      7'd120: qval = 9'd509;
      7'd121: qval = 9'd509;
      7'd122: qval = 9'd510;
      7'd123: qval = 9'd510;
      7'd124: qval = 9'd511;
      7'd125: qval = 9'd511;
      7'd126: qval = 9'd511;
      7'd127: qval = 9'd511;
    endcase
  end

  // Upper half-period sits above midscale and the lower half mirrors it below. Neither branch can overflow.
  assign next_sample = quad[1] ? (10'd511 - {1'b0, qval}) : (10'd512 + {1'b0, qval});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= '0;
      sample <= 10'd512;
    end else begin
      sample <= next_sample;
      phase  <= phase + 9'd1;
    end
  end

  assign dac_bit9 = sample[9];
  assign dac_bit8 = sample[8];
  assign dac_bit7 = sample[7];
  assign dac_bit6 = sample[6];
  assign dac_bit5 = sample[5];
  assign dac_bit4 = sample[4];
  assign dac_bit3 = sample[3];
  assign dac_bit2 = sample[2];
  assign dac_bit1 = sample[1];
  assign dac_bit0 = sample[0];

endmodule

// File: tb/tb_mp3_sine_gen.sv
// Bench for mp3_sine_gen. The reference waveform is built from real-valued sin().
// The bench also checks symmetry, period and reset properties.
module tb_mp3_sine_gen;

  localparam real PI = 3.14159265358979323846;
  localparam int NCAP = 1250;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dac_bit9, dac_bit8, dac_bit7, dac_bit6, dac_bit5;
  logic dac_bit4, dac_bit3, dac_bit2, dac_bit1, dac_bit0;
  logic [9:0] s;

  int n_tests = 0;
  int n_fail  = 0;
  int qtab [128];
  int cap  [NCAP+1];
  int ph;

  mp3_sine_gen dut (
    .clk(clk), .rst_n(rst_n),
    .dac_bit9(dac_bit9), .dac_bit8(dac_bit8), .dac_bit7(dac_bit7), .dac_bit6(dac_bit6),
    .dac_bit5(dac_bit5), .dac_bit4(dac_bit4), .dac_bit3(dac_bit3), .dac_bit2(dac_bit2),
    .dac_bit1(dac_bit1), .dac_bit0(dac_bit0)
  );

  always #5 clk = ~clk;

  assign s = {dac_bit9, dac_bit8, dac_bit7, dac_bit6, dac_bit5,
              dac_bit4, dac_bit3, dac_bit2, dac_bit1, dac_bit0};

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int model_f(input int p);
    int q;
    int i;
    q = (p % 512) / 128;
    i = p % 128;
    case (q)
      0:       return 512 + qtab[i];
      1:       return 512 + qtab[127 - i];
      2:       return 511 - qtab[i];
      default: return 511 - qtab[127 - i];
    endcase
  endfunction

  // Check each pin individually against the bits of an expected code.
  task automatic chk_pins(input string tag, input int exp);
    logic [9:0] e;
    e = exp[9:0];
    for (int j = 0; j < 10; j++)
      chk($sformatf("%s_bit%0d", tag, j), int'(s[j]), int'(e[j]));
  endtask

  // One clock of free-running output, compared with the model at the tracked phase.
  task automatic step_check(input string tag);
    @(posedge clk);
    #1;
    chk(tag, int'(s), model_f(ph));
    chk({tag, "_not_mid"}, int'(s != 10'd512), 1);
    ph = (ph + 1) % 512;
  endtask

  // Pull reset between edges, confirm it acts before the next edge, then release.
  task automatic async_reset(input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mid", int'(s), 512);
    repeat (hold) begin
      @(negedge clk);
      chk("async_rst_hold", int'(s), 512);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ph = 0;
    @(posedge clk);
    #1;
    chk("after_rst_first", int'(s), 515);
    ph = 1;
  endtask

  initial begin
    for (int k = 0; k < 128; k++)
      qtab[k] = int'($floor(511.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 512.0) + 0.5));

    chk("qtab0", qtab[0], 3);
    chk("qtab1", qtab[1], 9);
    chk("qtab127", qtab[127], 511);

    // Reset held for three clocks.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_state", int'(s), 512);
    end
    chk_pins("pins_512", 512);
    rst_n = 1'b1;
    ph = 0;

    // Golden capture of about 2.4 periods.
    for (int k = 1; k <= NCAP; k++) begin
      @(posedge clk);
      #1;
      cap[k] = int'(s);
      chk("golden", cap[k], model_f(ph));
      if (k == 1)   chk_pins("pins_515", 515);
      if (k == 128) chk_pins("pins_1023", 1023);
      if (k == 384) chk_pins("pins_0", 0);
      ph = (ph + 1) % 512;
    end

    chk("edge1", cap[1], 515);
    chk("edge2", cap[2], 521);
    chk("peak128", cap[128], 1023);
    chk("peak129", cap[129], 1023);
    chk("trough384", cap[384], 0);
    chk("trough385", cap[385], 0);
    chk("zc256", cap[256], 515);
    chk("zc257", cap[257], 508);
    chk("wrap512", cap[512], 508);
    chk("wrap513", cap[513], 515);

    for (int k = 1; k + 256 <= NCAP; k++)
      chk("antisym", cap[k] + cap[k + 256], 1023);
    for (int k = 1; k + 512 <= NCAP; k++)
      chk("period", cap[k + 512], cap[k]);
    for (int n = 0; n < 256; n++)
      chk("mirror", cap[n + 1], cap[256 - n]);
    for (int k = 1; k <= NCAP; k++)
      chk("no_midscale", int'(cap[k] != 512), 1);
    for (int k = 2; k <= 128; k++)
      chk("rise_a", int'(cap[k] >= cap[k - 1]), 1);
    for (int k = 130; k <= 384; k++)
      chk("fall", int'(cap[k] <= cap[k - 1]), 1);
    for (int k = 386; k <= 512; k++)
      chk("rise_b", int'(cap[k] >= cap[k - 1]), 1);
    chk("rise_span", int'(cap[128] > cap[1]), 1);

    // Directed asynchronous reset at sample 200 of a fresh run.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ph = 0;
    for (int k = 1; k <= 200; k++) step_check("pre200");
    async_reset(1);
    for (int k = 0; k < 20; k++) step_check("post200");

    // Randomised run lengths and reset points.
    for (int r = 0; r < 12; r++) begin
      int len;
      len = int'($urandom_range(1, 700));
      for (int k = 0; k < len; k++) step_check("rand_run");
      async_reset(int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 50; k++) step_check("rand_tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
